// File: rtl/optical_frame_rx.sv
// Receive framer: oversamples rx_in, finds the start bit, and recovers 28 data bits plus parity.
module optical_frame_rx #(
  parameter int unsigned CYCLES_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  output logic [27:0] data_out,
  output logic        parity_bit,
  output logic        data_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam int unsigned CW       = $clog2(CYCLES_PER_BIT);
  localparam int unsigned DW       = 28;
  localparam int unsigned SW       = DW + 1;
  localparam int unsigned IW       = 5;
  localparam logic [CW-1:0] HALF_M1  = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [DW-1:0]   data_q, data_d;
  logic            parity_q, parity_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;

  // Next-state and output decode; IDLE->START preloads the counter so the
  // start-bit sample lands at mid-bit with the two synchronizer flops included.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    parity_d = parity_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = CW'(1);
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[SW-1:1]};
          if (idx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d   = shift_q[DW-1:0];
            parity_d = shift_q[SW-1];
            valid_d  = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out    = data_q;
  assign parity_bit  = parity_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_optical_frame_rx.sv
// Bench for optical_frame_rx: directed plus random frames against a timing/event model.
module tb_optical_frame_rx;

  localparam int C = 16;

  logic        clk;
  logic        rst;
  logic        rx_in;
  logic [27:0] data_out;
  logic        parity_bit;
  logic        data_valid;
  logic        frame_error;
  logic        busy;

  optical_frame_rx #(.CYCLES_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .parity_bit (parity_bit),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame event: start = cycle count when the start bit was driven.
  typedef struct {
    int          start;
    int          due;
    logic [27:0] d;
    logic        p;
    logic        stp;
  } exp_t;

  exp_t        exp_q[$];
  int          vtimes[$];
  int          cyc;
  int          checks;
  int          errors;
  int          ign_lo;
  int          ign_hi;
  logic [27:0] held_d;
  logic        held_p;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Per-cycle monitor: pulses, held word and busy against the model.
  always @(negedge clk) begin
    logic exp_v, exp_e, exp_b;
    exp_t e;
    if (rst) begin
      held_d = '0;
      held_p = 1'b0;
      check("rst_valid", 32'(data_valid), 32'(1'b0));
      check("rst_ferr", 32'(frame_error), 32'(1'b0));
      check("rst_busy", 32'(busy), 32'(1'b0));
      check("rst_data", 32'(data_out), 32'(0));
      check("rst_parity", 32'(parity_bit), 32'(1'b0));
    end else begin
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (data_valid) vtimes.push_back(cyc);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.stp) begin
          exp_v  = 1'b1;
          held_d = e.d;
          held_p = e.p;
        end else begin
          exp_e  = 1'b1;
          ign_lo = cyc + 1;
          ign_hi = cyc + C;
        end
      end
      exp_b = 1'b0;
      foreach (exp_q[i])
        if (cyc >= exp_q[i].start + 3 && cyc < exp_q[i].due) exp_b = 1'b1;
      check("data_valid", 32'(data_valid), 32'(exp_v));
      check("frame_error", 32'(frame_error), 32'(exp_e));
      check("data_out", 32'(data_out), 32'(held_d));
      check("parity_bit", 32'(parity_bit), 32'(held_p));
      if (!(cyc >= ign_lo && cyc <= ign_hi))
        check("busy", 32'(busy), 32'(exp_b));
    end
  end

  // Drive nbits bits of a frame (start, 28 data LSB first, parity, stop).
  task automatic send_frame(input logic [27:0] d, input logic p, input logic stp, input int nbits);
    logic [30:0] fr;
    exp_t e;
    fr = {stp, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < C; j++) begin
        @(negedge clk);
        if (i == 0 && j == 0) begin
          e.start = cyc;
          e.due   = (nbits == 31) ? cyc + C / 2 + 2 + 30 * C : cyc + 1000000;
          e.d     = d;
          e.p     = p;
          e.stp   = stp;
          exp_q.push_back(e);
        end
        // A low stop bit is released just after its mid-bit sample so the
        // line is back to idle before the framer's next start check.
        if (i == 30 && stp == 1'b0 && j > C / 2) rx_in = 1'b1;
        else                                     rx_in = fr[i];
      end
    end
    if (nbits == 31 && stp == 1'b0)
      repeat (C) begin
        @(negedge clk);
        rx_in = 1'b1;
      end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    ign_lo = cyc;
    ign_hi = cyc + len + C + 4;
    rx_in  = 1'b0;
    repeat (len - 1) @(negedge clk);
    idle(C + 4);
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    rx_in = 1'b1;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int g;
    logic [27:0] rd;
    checks = 0;
    errors = 0;
    ign_lo = 1;
    ign_hi = 0;
    held_d = '0;
    held_p = 1'b0;
    cyc    = 0;
    rst    = 1'b1;
    rx_in  = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    check("post_rst_data", 32'(data_out), 32'(0));
    check("post_rst_busy", 32'(busy), 32'(1'b0));

    send_frame(28'h0000001, 1'b1, 1'b1, 31);
    idle(20);
    check("single_data", 32'(data_out), 32'h0000001);
    check("single_parity", 32'(parity_bit), 32'(1'b1));

    glitch(3);
    check("glitch_data", 32'(data_out), 32'h0000001);

    send_frame(28'hFFFFFFE, 1'b1, 1'b0, 31);
    idle(10);
    check("ferr_data_kept", 32'(data_out), 32'h0000001);

    vtimes.delete();
    send_frame(28'h94BA8F8, 1'b1, 1'b1, 31);
    send_frame(28'h0000001, 1'b1, 1'b1, 31);
    idle(20);
    check("b2b_count", 32'(vtimes.size()), 32'(2));
    if (vtimes.size() == 2)
      check("b2b_spacing", 32'(vtimes[1] - vtimes[0]), 32'(31 * C));

    send_frame(28'h5A5A5A5, 1'b0, 1'b1, 11);
    pulse_reset(5);
    idle(10);
    check("abort_data", 32'(data_out), 32'(0));
    send_frame(28'h0000001, 1'b1, 1'b1, 31);
    idle(20);
    check("after_abort_data", 32'(data_out), 32'h0000001);
    check("after_abort_parity", 32'(parity_bit), 32'(1'b1));

    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        glitch(int'($urandom_range(1, C / 2 - 1)));
      end else begin
        rd = 28'($urandom);
        send_frame(rd, 1'($urandom), ($urandom_range(0, 3) != 0), 31);
        g = int'($urandom_range(0, 10));
        if (g > 0) idle(g);
      end
    end

    idle(40);
    check("pending", 32'(exp_q.size()), 32'(0));
    check("final_busy", 32'(busy), 32'(1'b0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/optical_frame_rx.md
# optical_frame_rx

Receive-side framer for the optical link. It oversamples the demodulated photodiode bit stream and detects each frame's start bit. It then recovers 28 data bits plus one transmitted parity bit, and presents them as a registered word with a one-cycle valid strobe. It sits directly upstream of the parity checker, which consumes `data_out` and compares its computed parity against `parity_bit`.

## Interface
- `CYCLES_PER_BIT`, default 16: clock cycles per line bit. Must be even and ≥ 4.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rx_in`, input, 1: raw serial line, asynchronous to `clk`. The line idles high.
- `data_out`, output, 28: last successfully framed data word, bit 0 first on the line.
- `parity_bit`, output, 1: parity bit received with `data_out`.
- `data_valid`, output, 1: one-cycle pulse when `data_out`/`parity_bit` update.
- `frame_error`, output, 1: one-cycle pulse when a frame's stop bit samples low.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- Line format: start bit (0), then 28 data bits LSB first, then parity bit, then stop bit (1). One frame is 31 bits.
- Synchronizer: `rx_in` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- Counters:
  - cycle counter, width `$clog2(CYCLES_PER_BIT)`.
  - bit index, 0..28.
  - 29-bit shift register. Each new sample enters at bit 28 and the register shifts right. After 29 samples, bits [27:0] hold the data and bit 28 holds the parity bit.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: counter = 0. If `rx_s`==0, go to START.
  - START: counter increments. When counter == `CYCLES_PER_BIT/2-1`, sample `rx_s`:
    - 0: go to DATA, clear counter and bit index.
    - 1: treat as a glitch and return to IDLE with no pulse.
  - DATA: counter increments. When counter == `CYCLES_PER_BIT-1`, shift in `rx_s` and clear the counter. After the sample at bit index 28, go to STOP; otherwise increment the bit index.
  - STOP: when counter == `CYCLES_PER_BIT-1`, sample `rx_s` and go to IDLE:
    - 1: load `data_out` ← shift[27:0] and `parity_bit` ← shift[28], and pulse `data_valid`.
    - 0: pulse `frame_error`. `data_out` and `parity_bit` keep their previous values.
- Samples therefore fall at mid-bit. The FSM returns to IDLE at the middle of the stop bit, so a start bit that immediately follows the stop bit is caught.
- Output behaviour:
  - `data_out` and `parity_bit` hold their values until the next good frame.
  - `data_valid` and `frame_error` are never high in the same cycle.
- The block does not check parity; that is the downstream checker's job.

## Timing
- Reset values: `data_out`=0, `parity_bit`=0, `data_valid`=0, `frame_error`=0, `busy`=0. FSM = IDLE and all counters = 0.
- Reset mid-frame: the block returns to IDLE at once and produces no pulse. The partial frame is discarded.
- Latency: let edge 0 be the first clock edge that samples `rx_in` low.
  - FSM enters START at edge 2.
  - Data bit k is sampled at edge 2 + `CYCLES_PER_BIT/2` − 1 + (k+1)·`CYCLES_PER_BIT`.
  - `data_valid` is high in the cycle after edge `CYCLES_PER_BIT/2` + 1 + 30·`CYCLES_PER_BIT`. For the default of 16 this is edge 489.
- `busy` rises the cycle after `rx_s` is seen low in IDLE. It falls the cycle `data_valid`/`frame_error` rises, or the cycle after a glitch reject.
- Start glitch: a low pulse shorter than `CYCLES_PER_BIT/2` cycles is rejected. Within an idle line there is no minimum gap between frames.
- Throughput: the block accepts one frame per 31·`CYCLES_PER_BIT` cycles, back-to-back.

## Test plan
- Reset with `rx_in`=1 held for 50 cycles, then release → all outputs 0, `busy`=0, no pulses.
- Single frame, data 28'h0000001, parity 1, stop 1, `CYCLES_PER_BIT`=16 → `data_valid` exactly one cycle after edge 489; `data_out`=28'h0000001, `parity_bit`=1.
- Glitch: `rx_in` low for 3 cycles, then high → `busy` pulses briefly; no `data_valid` and no `frame_error`; `data_out` unchanged.
- Framing error: frame of 28'hFFFFFFE with the stop bit driven 0 → `frame_error` one cycle at the same edge `data_valid` would have fired; `data_out` keeps its prior value of 28'h0000001.
- Back-to-back frames, 28'h94BA8F8 (parity 1) then 28'h0000001 (parity 1), with no idle gap → two `data_valid` pulses 496 cycles apart, with the correct words and parity bits in order.
- Reset asserted at bit index 10 of a frame, released 5 cycles later → no pulse from the aborted frame; a following good frame of 28'h0000001 (parity 1) is received correctly.
